// File: rtl/parking_pkg.sv
// Shared types, panel glyphs and sizing helper for the parking gate controller.
// Build option: PARKING_LOCKOUT_EN makes the LOCKOUT state reachable.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASSWORD,
    WRONG_PASS,
    RIGHT_PASS,
    STOP,
    FULL,
    LOCKOUT
  } state_t;

  typedef struct packed {
    logic [6:0] left;
    logic [6:0] right;
  } glyph_pair_t;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_C     = 7'h46;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  function automatic glyph_pair_t glyph(input state_t s);
    glyph_pair_t g;
    case (s)
      WAIT_PASSWORD: g = {SEG_E, SEG_N};
      WRONG_PASS:    g = {SEG_E, SEG_E};
      RIGHT_PASS:    g = {SEG_G, SEG_O};
      STOP:          g = {SEG_S, SEG_P};
      FULL:          g = {SEG_F, SEG_L};
      LOCKOUT:       g = {SEG_L, SEG_C};
      default:       g = {SEG_BLANK, SEG_BLANK};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Gate sensor / keypad inputs and panel outputs of the parking gate controller.
// Build option: PARKING_LOCKOUT_EN (no effect on this bundle of signals).
interface parking_gate_ctrl_if #(
  parameter int PW_W  = 2,
  parameter int OCC_W = 4
);
  logic            sensor_entrance;
  logic            sensor_exit;
  logic            car_depart;
  logic            pass_valid;
  logic [PW_W-1:0] pass_1;
  logic [PW_W-1:0] pass_2;
  logic            green_led;
  logic            red_led;
  logic [6:0]      hex_1;
  logic [6:0]      hex_2;
  logic [OCC_W-1:0] occupancy;
  logic            lot_full;

  modport master (
    output sensor_entrance, sensor_exit, car_depart,
    output pass_valid, pass_1, pass_2,
    input  green_led, red_led, hex_1, hex_2,
    input  occupancy, lot_full
  );

  modport slave (
    input  sensor_entrance, sensor_exit, car_depart,
    input  pass_valid, pass_1, pass_2,
    output green_led, red_led, hex_1, hex_2,
    output occupancy, lot_full
  );
endinterface

// File: rtl/parking_blink_gen.sv
// Registered LED driver: solid on, off, or toggling every BLINK_DIV cycles.
// Build option: PARKING_LOCKOUT_EN (not used here).
module parking_blink_gen
  import parking_pkg::*;
#(
  parameter int BLINK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic en,
  input  logic solid,
  output logic led
);

  localparam int CW = cnt_w(BLINK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  // A fresh blink state always shows the LED dark first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (solid) begin
      cnt <= '0;
      led <= 1'b1;
    end else if (restart || !en) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      led <= ~led;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entrance gate FSM with password window, tailgate stop and lot occupancy.
// Build option: PARKING_LOCKOUT_EN adds a timed LOCKOUT after MAX_TRIES misses.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int PW_W = 2,
  parameter logic [PW_W-1:0] PASS_1 = PW_W'(2'b01),
  parameter logic [PW_W-1:0] PASS_2 = PW_W'(2'b10),
  parameter int CAPACITY = 8,
  parameter int WAIT_CYCLES = 4,
  parameter int BLINK_DIV = 1,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic clk,
  input logic reset_n,
  parking_gate_ctrl_if.slave bus
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);
  localparam int WW = cnt_w(WAIT_CYCLES);
  localparam logic [WW-1:0] WAIT_V = WW'(WAIT_CYCLES);
  localparam int TW = cnt_w(MAX_TRIES);
  localparam logic [TW-1:0] TRY_V = TW'(MAX_TRIES);
`ifdef PARKING_LOCKOUT_EN
  localparam int LW = cnt_w(LOCK_CYCLES);
  localparam logic [LW-1:0] LOCK_V = LW'(LOCK_CYCLES - 1);
  logic [LW-1:0] lock_cnt;
`endif

  state_t state;
  state_t shown;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] try_cnt;
  logic [TW-1:0] try_inc;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;
  logic full;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic match;
  logic gate_pass;
  logic restart;
  logic red_solid;
  logic red_blink;
  logic green_blink;

  assign match = bus.pass_valid
              && bus.pass_1 == PASS_1
              && bus.pass_2 == PASS_2;
  assign gate_pass = state == RIGHT_PASS
                  && bus.sensor_exit
                  && !bus.sensor_entrance;
  assign try_inc = (try_cnt == TRY_V)
                 ? try_cnt : try_cnt + 1'b1;

  always_comb begin
    occ_nxt = occ;
    unique case (1'b1)
      gate_pass && !bus.car_depart:
        if (occ != CAP_V) occ_nxt = occ + 1'b1;
      bus.car_depart && !gate_pass:
        if (occ != '0) occ_nxt = occ - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shown    <= IDLE;
      wait_cnt <= '0;
      try_cnt  <= '0;
      occ      <= '0;
      full     <= 1'b0;
      hex_l    <= SEG_BLANK;
      hex_r    <= SEG_BLANK;
`ifdef PARKING_LOCKOUT_EN
      lock_cnt <= '0;
`endif
    end else begin
      shown          <= state;
      {hex_l, hex_r} <= glyph(state);
      occ            <= occ_nxt;
      full           <= occ_nxt == CAP_V;
      wait_cnt       <= '0;
      case (state)
        IDLE:
          if (bus.sensor_entrance)
            state <= full ? FULL : WAIT_PASSWORD;
        WAIT_PASSWORD:
          if (wait_cnt < WAIT_V) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else if (match) begin
            state   <= RIGHT_PASS;
            try_cnt <= '0;
          end else if (bus.pass_valid) begin
            state   <= WRONG_PASS;
            try_cnt <= try_inc;
          end else begin
            wait_cnt <= wait_cnt;
          end
        WRONG_PASS:
`ifdef PARKING_LOCKOUT_EN
          if (try_cnt >= TRY_V) begin
            state    <= LOCKOUT;
            lock_cnt <= '0;
          end else
`endif
          if (match) begin
            state   <= RIGHT_PASS;
            try_cnt <= '0;
          end else if (bus.pass_valid) begin
            try_cnt <= try_inc;
          end
        RIGHT_PASS:
          if (bus.sensor_entrance && bus.sensor_exit)
            state <= STOP;
          else if (bus.sensor_exit)
            state <= IDLE;
        STOP:
          if (match) begin
            state   <= RIGHT_PASS;
            try_cnt <= '0;
          end
        FULL:
          if (!bus.sensor_entrance || !full)
            state <= IDLE;
`ifdef PARKING_LOCKOUT_EN
        LOCKOUT:
          if (lock_cnt == LOCK_V) begin
            state   <= IDLE;
            try_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign restart     = state != shown;
  assign red_solid   = state inside {WAIT_PASSWORD, FULL, LOCKOUT};
  assign red_blink   = state inside {WRONG_PASS, STOP};
  assign green_blink = state == RIGHT_PASS;

  parking_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_red (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .en      (red_blink),
    .solid   (red_solid),
    .led     (bus.red_led)
  );

  parking_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_green (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .en      (green_blink),
    .solid   (1'b0),
    .led     (bus.green_led)
  );

  assign bus.hex_1     = hex_l;
  assign bus.hex_2     = hex_r;
  assign bus.occupancy = occ;
  assign bus.lot_full  = full;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Random and directed stimulus against a behavioural gate/lot model.
// Build option: PARKING_LOCKOUT_EN enables the lockout model and checks.
module tb_parking_gate_ctrl;

  localparam int CAP   = 2;
  localparam int WAITC = 4;
  localparam int DIV   = 2;
  localparam int MAXT  = 3;
  localparam int LOCKC = 16;
  localparam int OW    = $clog2(CAP + 1);
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
`ifdef PARKING_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_WAIT  = 1;
  localparam int S_WRONG = 2;
  localparam int S_RIGHT = 3;
  localparam int S_STOP  = 4;
  localparam int S_FULL  = 5;
  localparam int S_LOCK  = 6;

  logic clk;
  logic reset_n;

  parking_gate_ctrl_if #(.PW_W(2), .OCC_W(OW)) bus ();

  parking_gate_ctrl #(
    .PW_W(2), .PASS_1(P1), .PASS_2(P2),
    .CAPACITY(CAP), .WAIT_CYCLES(WAITC),
    .BLINK_DIV(DIV), .MAX_TRIES(MAXT),
    .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  int ms, shown, age, wait_n, tries, lock_n, occ;
  bit full;
  int e_h1, e_h2, e_r, e_g;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Segment patterns written active-high (bit0=a), panel drives inverted.
  function automatic int seg(input logic [6:0] on);
    logic [6:0] v;
    v = ~on;
    return int'(v);
  endfunction

  function automatic int left_of(input int s);
    case (s)
      S_WAIT, S_WRONG: return seg(7'h79);
      S_RIGHT: return seg(7'h3D);
      S_STOP:  return seg(7'h6D);
      S_FULL:  return seg(7'h71);
      S_LOCK:  return seg(7'h38);
      default: return 'h7F;
    endcase
  endfunction

  function automatic int right_of(input int s);
    case (s)
      S_WAIT:  return seg(7'h54);
      S_WRONG: return seg(7'h79);
      S_RIGHT: return seg(7'h3F);
      S_STOP:  return seg(7'h73);
      S_FULL:  return seg(7'h38);
      S_LOCK:  return seg(7'h39);
      default: return 'h7F;
    endcase
  endfunction

  task automatic model_reset();
    ms = S_IDLE; shown = S_IDLE; age = 0;
    wait_n = 0; tries = 0; lock_n = 0;
    occ = 0; full = 0;
    e_h1 = 'h7F; e_h2 = 'h7F; e_r = 0; e_g = 0;
  endtask

  task automatic model_step();
    bit ent, ex, dep, att, ok, pass;
    int nx;
    ent = bus.sensor_entrance;
    ex  = bus.sensor_exit;
    dep = bus.car_depart;
    att = bus.pass_valid;
    ok  = att && bus.pass_1 == P1 && bus.pass_2 == P2;
    // panel shows the state held before this edge
    age   = (ms == shown) ? age + 1 : 0;
    shown = ms;
    e_h1  = left_of(ms);
    e_h2  = right_of(ms);
    if (ms == S_WAIT || ms == S_FULL || ms == S_LOCK) e_r = 1;
    else if (ms == S_WRONG || ms == S_STOP) e_r = (age / DIV) % 2;
    else e_r = 0;
    e_g = (ms == S_RIGHT) ? (age / DIV) % 2 : 0;
    nx = ms;
    pass = 0;
    case (ms)
      S_IDLE: if (ent) nx = full ? S_FULL : S_WAIT;
      S_WAIT:
        if (wait_n < WAITC) wait_n++;
        else if (ok) nx = S_RIGHT;
        else if (att) begin
          nx = S_WRONG;
          tries = (tries < MAXT) ? tries + 1 : tries;
        end
      S_WRONG:
        if (LOCK_EN && tries >= MAXT) begin
          nx = S_LOCK;
          lock_n = 0;
        end else if (ok) nx = S_RIGHT;
        else if (att) tries = (tries < MAXT) ? tries + 1 : tries;
      S_RIGHT:
        if (ent && ex) nx = S_STOP;
        else if (ex) begin
          nx = S_IDLE;
          pass = 1;
        end
      S_STOP: if (ok) nx = S_RIGHT;
      S_FULL: if (!ent || !full) nx = S_IDLE;
      S_LOCK: begin
        lock_n++;
        if (lock_n == LOCKC) begin
          nx = S_IDLE;
          tries = 0;
        end
      end
      default: nx = S_IDLE;
    endcase
    if (nx == S_RIGHT) tries = 0;
    if (nx != S_WAIT) wait_n = 0;
    occ = occ + int'(pass) - int'(dep);
    if (occ < 0) occ = 0;
    if (occ > CAP) occ = CAP;
    full = (occ == CAP);
    ms = nx;
  endtask

  task automatic compare_all();
    check("hex_1", 32'(bus.hex_1), e_h1);
    check("hex_2", 32'(bus.hex_2), e_h2);
    check("red_led", 32'(bus.red_led), e_r);
    check("green_led", 32'(bus.green_led), e_g);
    check("occupancy", 32'(bus.occupancy), occ);
    check("lot_full", 32'(bus.lot_full), 32'(full));
  endtask

  task automatic tick(input bit ent, input bit ex,
                      input bit dep, input bit pv,
                      input logic [1:0] a,
                      input logic [1:0] b);
    bus.sensor_entrance = ent;
    bus.sensor_exit     = ex;
    bus.car_depart      = dep;
    bus.pass_valid      = pv;
    bus.pass_1          = a;
    bus.pass_2          = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_in();
    bus.sensor_entrance = 0;
    bus.sensor_exit     = 0;
    bus.car_depart      = 0;
    bus.pass_valid      = 0;
    bus.pass_1          = '0;
    bus.pass_2          = '0;
  endtask

  task automatic mid_reset(input string tag);
    idle_in();
    reset_n = 1'b0;
    #1;
    check({tag, "_hex_1"}, 32'(bus.hex_1), 'h7F);
    check({tag, "_hex_2"}, 32'(bus.hex_2), 'h7F);
    check({tag, "_leds"},
          32'({bus.red_led, bus.green_led}), 0);
    check({tag, "_occ"}, 32'(bus.occupancy), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit ent, ex, dep, pv;
    logic [1:0] a, b;
    idle_in();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hex_1", 32'(bus.hex_1), 'h7F);
    check("rst_hex_2", 32'(bus.hex_2), 'h7F);
    check("rst_red", 32'(bus.red_led), 0);
    check("rst_green", 32'(bus.green_led), 0);
    check("rst_occ", 32'(bus.occupancy), 0);
    check("rst_full", 32'(bus.lot_full), 0);
    reset_n = 1'b1;

    // entry with an early (ignored) match at wait count 2
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, P1, P2);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, P1, P2);
    check("dir_en", 32'(bus.hex_1), seg(7'h79));
    tick(0, 0, 0, 0, 0, 0);
    check("dir_go", 32'(bus.hex_2), seg(7'h3F));
    tick(0, 1, 0, 0, 0, 0);
    check("dir_occ1", 32'(bus.occupancy), 1);

    // wrong, right, tailgate, right, admit to full
    tick(1, 0, 0, 0, 0, 0);
    repeat (4) tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 2'b11, P2);
    tick(1, 0, 0, 0, 0, 0);
    check("dir_ee", 32'(bus.hex_2), seg(7'h79));
    tick(1, 0, 0, 1, P1, P2);
    tick(1, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("dir_sp", 32'(bus.hex_1), seg(7'h6D));
    check("dir_tg_occ", 32'(bus.occupancy), 1);
    tick(0, 0, 0, 1, P1, P2);
    tick(0, 1, 0, 0, 0, 0);
    check("dir_full", 32'(bus.lot_full), 1);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    check("dir_fl", 32'(bus.hex_1), seg(7'h71));
    tick(1, 0, 1, 0, 0, 0);
    check("dir_dep", 32'(bus.occupancy), 1);
    tick(0, 0, 0, 0, 0, 0);

`ifdef PARKING_LOCKOUT_EN
    tick(1, 0, 0, 0, 0, 0);
    repeat (4) tick(1, 0, 0, 0, 0, 0);
    repeat (3) tick(1, 0, 0, 1, 2'b11, 2'b00);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, P1, P2);
    check("dir_lc", 32'(bus.hex_1), seg(7'h38));
    repeat (4) tick(1, 0, 0, 1, P1, P2);
    mid_reset("lock_rst");
`endif

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) mid_reset("rnd_rst");
      ent = $urandom_range(0, 99) < 60;
      ex  = $urandom_range(0, 99) < 25;
      dep = $urandom_range(0, 99) < 8;
      pv  = $urandom_range(0, 99) < 30;
      a = ($urandom_range(0, 99) < 65)
        ? P1 : 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 99) < 65)
        ? P2 : 2'($urandom_range(0, 3));
      tick(ent, ex, dep, pv, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
